uart_inject_scheduler: RTL and testbench
========================================

Name: uart_inject_scheduler

Overview:
Sequences fake-byte injection onto one UART interface of the MITM design. It buffers bytes from the bus-interface/command logic in a small FIFO and waits for the real passthrough line to go idle. It then takes over the output mux, feeds the driver one byte at a time and hands the line back after a guard time. One instance is placed per direction, driving the controller's fake_ifN_tx_select, fake_ifN_tx_start and fake_ifN_transmit_data.

Parameters:
SYS_FREQ_HZ, 12_000_000, system clock frequency
BAUD_RATE, 115_200, line rate; BIT_DURATION = SYS_FREQ_HZ / BAUD_RATE cycles (integer division)
NUM_DATA_BITS, 8, data bits per frame
FIFO_DEPTH, 8, injection FIFO entries; power of 2, >= 2
IDLE_BITS, 12, bit times the real line must stay high before takeover; must be >= NUM_DATA_BITS+2
GUARD_BITS, 1, bit times select is held after the last stop bit before release

Ports:
sys_clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
enable  in  1  allow takeover; when low, no new burst starts
push_valid  in  1  byte offered to FIFO
push_data  in  NUM_DATA_BITS  byte to inject
push_ready  out  1  FIFO not full
flush  in  1  synchronous clear of FIFO contents
real_rx_in  in  1  real passthrough source line (asynchronous)
tx_write_ready  in  1  driver idle/done, from controller
tx_start  out  1  one-cycle start pulse to controller
tx_data  out  NUM_DATA_BITS  byte presented to driver
tx_select  out  1  1 = fake line drives output mux
busy  out  1  state != IDLE
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
sent_pulse  out  1  one-cycle pulse per byte completed
overflow  out  1  sticky; push while full; cleared by flush

Behaviour:
- Reset (rst low, async): FIFO empty, state IDLE, all outputs 0 except push_ready=1, tx_data=0. Reset mid-burst releases tx_select immediately and discards FIFO contents.
- real_rx_in passes through a 2-flop synchronizer. idle_cnt increments while the synchronized line is high, saturates at IDLE_BITS*BIT_DURATION, and clears on any low sample. line_idle = saturated.
- FIFO: push accepted when push_valid & push_ready; push while full sets overflow and drops the byte. Pop happens on the tx_start cycle only. Push and pop in the same cycle leave the count unchanged and are legal when full. flush has priority over push in the same cycle; it does not abort a byte already started.
- States:
  - IDLE: go to WAIT_GAP when enable & count>0.
  - WAIT_GAP: go back to IDLE if !enable or count==0 (flush). Go to SELECT when line_idle.
  - SELECT: tx_select=1 for one settle cycle, then go to START.
  - START: if tx_write_ready, pulse tx_start and pop; tx_data = FIFO head, registered and held stable until the next START. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_write_ready low. If it is not low within 4 cycles, go to GUARD (error tolerance, no sent_pulse).
  - WAIT_DONE: on tx_write_ready high, pulse sent_pulse. If count>0 & enable, go to START (back-to-back, select held). Otherwise go to GUARD.
  - GUARD: hold tx_select for GUARD_BITS*BIT_DURATION cycles, then go to IDLE with tx_select=0.
- tx_select is continuously 1 from SELECT through the end of GUARD. The real line is never selected mid-burst.
- Deasserting enable mid-burst finishes the current byte, then goes to GUARD.
- Latency: first tx_start occurs 2 cycles after line_idle is first seen in WAIT_GAP, provided the driver is ready.

Decomposition:
- Shared package uart_pkg: BIT_DURATION function, state encoding localparams, counter-width helper.
- Sub-module sync_fifo (WIDTH, DEPTH): single-clock, count output, full/empty flags, same-cycle push/pop.

Test Plan:
- Default params (BIT_DURATION=104); line held high; push 0xA5 with enable=1 -> tx_select rises ~1248 cycles after line goes high; tx_start with tx_data=0xA5; sent_pulse after driver done; tx_select falls 104 cycles later.
- Push 0x11, 0x22, 0x33 -> three starts in order, tx_select never drops between bytes, fifo_count 3→0, three sent_pulses.
- Real frame: toggle real_rx_in low for 5 bit times during WAIT_GAP -> idle_cnt restarts; no tx_select until 1248 cycles after the last low.
- Push 9 bytes with enable=0, FIFO_DEPTH=8 -> push_ready=0 after 8; overflow=1; fifo_count=8. Then flush -> count=0, overflow=0, busy=0.
- Drop rst mid-byte in WAIT_DONE -> tx_select=0 and tx_start=0 asynchronously, fifo_count=0; after release, state stays IDLE.
- Hold tx_write_ready high after start (driver stuck) -> GUARD entered after 4 cycles, no sent_pulse, tx_select released after 104 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the UART injection path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_GAP,
    ST_SELECT,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GUARD
  } state_t;

  // Cycles the driver gets to acknowledge a start by dropping write_ready.
  localparam int unsigned BUSY_TIMEOUT = 4;

  function automatic int unsigned bit_duration(input int unsigned sys_freq_hz,
                                               input int unsigned baud_rate);
    return sys_freq_hz / baud_rate;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is taken
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_inject_scheduler.sv
// Queues fake bytes and injects them onto the UART output mux only after the
// real line has been idle long enough, holding the mux for a guard time.
module uart_inject_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned SYS_FREQ_HZ   = 12_000_000,
  parameter int unsigned BAUD_RATE     = 115_200,
  parameter int unsigned NUM_DATA_BITS = 8,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned IDLE_BITS     = 12,
  parameter int unsigned GUARD_BITS    = 1
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          push_valid,
  input  logic [NUM_DATA_BITS-1:0]      push_data,
  output logic                          push_ready,
  input  logic                          flush,
  input  logic                          real_rx_in,
  input  logic                          tx_write_ready,
  output logic                          tx_start,
  output logic [NUM_DATA_BITS-1:0]      tx_data,
  output logic                          tx_select,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          sent_pulse,
  output logic                          overflow
);

  localparam int unsigned BIT_DURATION = bit_duration(SYS_FREQ_HZ, BAUD_RATE);
  localparam int unsigned IDLE_CYCLES  = IDLE_BITS * BIT_DURATION;
  localparam int unsigned GUARD_CYCLES = GUARD_BITS * BIT_DURATION;
  localparam int unsigned TMR_MAX      = (GUARD_CYCLES > BUSY_TIMEOUT) ? GUARD_CYCLES : BUSY_TIMEOUT;
  localparam int unsigned IW           = cnt_width(IDLE_CYCLES);
  localparam int unsigned TW           = cnt_width(TMR_MAX);

  state_t                   state;
  state_t                   state_next;
  logic [1:0]               rx_sync;
  logic [IW-1:0]            idle_cnt;
  logic                     line_idle;
  logic [TW-1:0]            tmr;
  logic                     pop;
  logic [NUM_DATA_BITS-1:0] fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;

  sync_fifo #(
    .WIDTH (NUM_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (rst),
    .flush     (flush),
    .push      (push_valid),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign push_ready = ~fifo_full;
  assign busy       = (state != ST_IDLE);
  assign line_idle  = (idle_cnt == IW'(IDLE_CYCLES));

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      rx_sync  <= '0;
      idle_cnt <= '0;
    end else begin
      rx_sync <= {rx_sync[0], real_rx_in};
      if (!rx_sync[1])     idle_cnt <= '0;
      else if (!line_idle) idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    pop        = 1'b0;
    sent_pulse = 1'b0;
    case (state)
      ST_IDLE:      if (enable && !fifo_empty) state_next = ST_WAIT_GAP;
      ST_WAIT_GAP: begin
        if (!enable || fifo_empty) state_next = ST_IDLE;
        else if (line_idle)        state_next = ST_SELECT;
      end
      ST_SELECT:    state_next = ST_START;
      // A flush while settling leaves nothing to send; release via guard.
      ST_START: begin
        if (fifo_empty) begin
          state_next = ST_GUARD;
        end else if (tx_write_ready) begin
          tx_start   = 1'b1;
          pop        = 1'b1;
          state_next = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!tx_write_ready)                     state_next = ST_WAIT_DONE;
        else if (tmr == TW'(BUSY_TIMEOUT - 1))   state_next = ST_GUARD;
      end
      ST_WAIT_DONE: begin
        if (tx_write_ready) begin
          sent_pulse = 1'b1;
          state_next = (!fifo_empty && enable) ? ST_START : ST_GUARD;
        end
      end
      ST_GUARD:     if (tmr == TW'(GUARD_CYCLES - 1)) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      tx_select <= 1'b0;
      tx_data   <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      tmr       <= (state_next != state) ? '0 : tmr + 1'b1;
      tx_select <= state_next inside {ST_SELECT, ST_START, ST_WAIT_BUSY, ST_WAIT_DONE, ST_GUARD};
      // Head is captured on the way into START so it is stable during the pulse.
      if (state_next == ST_START) tx_data <= fifo_head;
      if (flush)                                       overflow <= 1'b0;
      else if (push_valid && fifo_full && !pop)        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_inject_scheduler.sv
// Randomized bench for uart_inject_scheduler with a queue-based reference model
// and a small emulation of the UART driver handshake.
module tb_uart_inject_scheduler;

  localparam int unsigned BD        = 12_000_000 / 115_200;
  localparam int unsigned IDLE_CYC  = 12 * BD;
  localparam int unsigned GUARD_CYC = 1 * BD;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned HSZ       = 4096;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       push_valid = 1'b0;
  logic [7:0] push_data = '0;
  logic       flush = 1'b0;
  logic       real_rx_in = 1'b1;
  logic       tx_write_ready = 1'b1;
  logic       push_ready, tx_start, tx_select, busy, sent_pulse, overflow;
  logic [7:0] tx_data;
  logic [3:0] fifo_count;

  uart_inject_scheduler #(
    .SYS_FREQ_HZ   (12_000_000),
    .BAUD_RATE     (115_200),
    .NUM_DATA_BITS (8),
    .FIFO_DEPTH    (DEPTH),
    .IDLE_BITS     (12),
    .GUARD_BITS    (1)
  ) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .enable         (enable),
    .push_valid     (push_valid),
    .push_data      (push_data),
    .push_ready     (push_ready),
    .flush          (flush),
    .real_rx_in     (real_rx_in),
    .tx_write_ready (tx_write_ready),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .tx_select      (tx_select),
    .busy           (busy),
    .fifo_count     (fifo_count),
    .sent_pulse     (sent_pulse),
    .overflow       (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state, owned by the monitor.
  byte unsigned exp_q[$];
  int  m_cnt = 0;
  bit  m_ovf = 0;
  int  cyc = 0;
  bit  hist [HSZ];
  bit  prev_sel = 0;
  int  exp_fall = -1;
  bit  wait_low = 0;
  int  busy_win = 0;
  bit  wait_done = 0;
  bit  expect_start = 0;
  bit  start_seen = 0;
  int  sent_cnt = 0;
  int  start_cnt = 0;
  bit  strict_gap = 0;
  bit  stuck = 0;

  always @(negedge sys_clk) begin
    int  pre;
    bit  popd;
    bit  ok;
    cyc++;
    hist[cyc % HSZ] = rst ? real_rx_in : 1'b0;
    start_seen = rst && tx_start;
    if (!rst) begin
      exp_q.delete();
      m_cnt = 0; m_ovf = 0; prev_sel = 0; exp_fall = -1;
      wait_low = 0; wait_done = 0; expect_start = 0;
    end else begin
      check("fifo_count", fifo_count, m_cnt);
      check("push_ready", push_ready, m_cnt < DEPTH);
      check("overflow", overflow, m_ovf);

      if (expect_start) begin
        if (tx_write_ready && m_cnt > 0) check("start_latency", tx_start, 1);
        expect_start = 0;
      end
      if (tx_select && !prev_sel) begin
        // The real line must have been sampled high for the whole idle window.
        ok = (cyc > int'(IDLE_CYC) + 4);
        for (int i = cyc - int'(IDLE_CYC) - 3; ok && i <= cyc - 4; i++)
          if (!hist[i % HSZ]) ok = 0;
        check("gap_idle", ok, 1);
        if (strict_gap) check("gap_exact", hist[(cyc - int'(IDLE_CYC) - 4) % HSZ], 0);
        expect_start = 1;
      end
      if (!tx_select && prev_sel) begin
        check("release_time", cyc, exp_fall);
        exp_fall = -1;
      end

      if (wait_done && tx_write_ready) begin
        check("sent_pulse", sent_pulse, 1);
        check("select_at_sent", tx_select, 1);
        sent_cnt++;
        wait_done = 0;
        if (!(m_cnt > 0 && enable)) exp_fall = cyc + 1 + int'(GUARD_CYC);
      end else begin
        check("no_sent", sent_pulse, 0);
      end
      if (wait_low) begin
        if (!tx_write_ready) begin
          wait_low = 0;
          wait_done = 1;
        end else begin
          busy_win++;
          if (busy_win == 4) begin
            wait_low = 0;
            exp_fall = cyc + 1 + int'(GUARD_CYC);
          end
        end
      end

      if (tx_start) begin
        start_cnt++;
        check("select_at_start", tx_select, 1);
        check("start_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("tx_data", tx_data, exp_q[0]);
        wait_low = 1;
        busy_win = 0;
        exp_fall = -1;
      end

      pre = m_cnt;
      if (flush) begin
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 0;
      end else begin
        popd = tx_start && pre > 0;
        if (popd) begin
          void'(exp_q.pop_front());
          m_cnt--;
        end
        if (push_valid) begin
          if (pre < DEPTH || popd) begin
            exp_q.push_back(push_data);
            m_cnt++;
          end else begin
            m_ovf = 1;
          end
        end
      end
      prev_sel = tx_select;
    end
  end

  // Driver emulation: acknowledges a start by dropping ready, then finishes.
  int drv_dly = 0;
  int drv_busy = 0;
  bit drv_act = 0;
  always @(posedge sys_clk) begin
    #1;
    if (!rst) begin
      tx_write_ready = 1'b1;
      drv_act = 0;
    end else if (start_seen && !stuck) begin
      drv_dly  = $urandom_range(0, 2);
      drv_busy = $urandom_range(2, 12);
      drv_act  = 1;
      if (drv_dly == 0) tx_write_ready = 1'b0;
    end else if (drv_act) begin
      if (tx_write_ready) begin
        if (drv_dly > 0) drv_dly--;
        if (drv_dly == 0) tx_write_ready = 1'b0;
      end else begin
        drv_busy--;
        if (drv_busy == 0) begin
          tx_write_ready = 1'b1;
          drv_act = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    push_valid = 1'b1;
    push_data  = b;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int max_cyc);
    bit done = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      tick();
      if (!busy && m_cnt == 0 && !tx_select) done = 1;
    end
    check({"quiet_", tag}, done, 1);
  endtask

  initial begin
    int low_left = 0;
    bit found = 0;
    repeat (3) tick();
    check("rst_push_ready", push_ready, 1);
    check("rst_tx_select", tx_select, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx_data", tx_data, 0);
    rst = 1'b1;

    // Single byte from a freshly idle line.
    enable = 1'b1;
    push_byte(8'hA5);
    wait_quiet("single", 4000);
    check("single_sent", sent_cnt, 1);

    // Three queued bytes go out back-to-back.
    enable = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    check("burst_count", fifo_count, 3);
    enable = 1'b1;
    wait_quiet("burst", 4000);
    check("burst_sent", sent_cnt, 4);

    // Real traffic restarts the idle window.
    real_rx_in = 1'b0;
    repeat (3 * BD) tick();
    push_byte(8'h5A);
    repeat (2 * BD) tick();
    check("gap_no_select", tx_select, 0);
    real_rx_in = 1'b1;
    strict_gap = 1;
    wait_quiet("gap", 4000);
    strict_gap = 0;
    check("gap_sent", sent_cnt, 5);

    // Overflow and flush.
    enable = 1'b0;
    for (int i = 0; i < 9; i++) push_byte(8'($urandom));
    check("ovf_count", fifo_count, 8);
    check("ovf_ready", push_ready, 0);
    check("ovf_flag", overflow, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_count", fifo_count, 0);
    check("flush_ovf", overflow, 0);
    check("flush_busy", busy, 0);

    // Stuck driver: never acknowledges, guard still releases the line.
    enable = 1'b1;
    stuck = 1;
    push_byte(8'hC3);
    wait_quiet("stuck", 4000);
    stuck = 0;
    check("stuck_no_sent", sent_cnt, 5);

    // Reset while a byte is in flight.
    push_byte(8'h01);
    push_byte(8'h02);
    for (int i = 0; i < 4000 && !found; i++) begin
      tick();
      if (wait_done) found = 1;
    end
    check("reach_wait_done", found, 1);
    tick();
    rst = 1'b0;
    #1;
    check("arst_select", tx_select, 0);
    check("arst_start", tx_start, 0);
    check("arst_count", fifo_count, 0);
    check("arst_busy", busy, 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (50) tick();
    check("post_rst_idle", busy, 0);

    // Randomized traffic.
    for (int i = 0; i < 15000; i++) begin
      push_valid = ($urandom_range(0, 15) == 0);
      push_data  = 8'($urandom);
      flush      = (!busy && $urandom_range(0, 399) == 0);
      if ($urandom_range(0, 1499) == 0) enable = ~enable;
      if (low_left > 0) begin
        low_left--;
        real_rx_in = (low_left == 0);
      end else if ($urandom_range(0, 1999) == 0) begin
        low_left = $urandom_range(20, 600);
        real_rx_in = 1'b0;
      end
      tick();
    end
    push_valid = 1'b0;
    flush      = 1'b0;
    enable     = 1'b1;
    real_rx_in = 1'b1;
    wait_quiet("random", 20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
